fetch_unit_squash: RTL and testbench

In-order instruction fetch stage that sits directly upstream of the decode/issue unit. It issues sequential 4-byte instruction requests to instruction memory and tags each returned instruction with its PC and a sequence number. Instructions go to decode over the F→D valid/ready channel. When decode signals a squash, the unit redirects to the jump target and discards every response that is still in flight.

---
 rtl/fetch_unit_squash_pkg.sv | 6 +
 rtl/fetch_unit_squash_if.sv | 33 +++
 rtl/fetch_unit_squash_pc_queue.sv | 47 ++++
 rtl/fetch_unit_squash.sv | 83 ++++++++
 tb/tb_fetch_unit_squash.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_squash_pkg.sv
// Shared fetch definitions: reset PC, sequence-number width and instruction size.
package fetch_unit_squash_pkg;
    localparam logic [31:0] RST_ADDR     = 32'h200;
    localparam int          SEQ_NUM_BITS = 5;
    localparam int          INST_BYTES   = 4;
endpackage

// File: rtl/fetch_unit_squash_if.sv
// Fetch-stage channels: I-mem request/response, F->D instruction, and squash from decode.
interface fetch_unit_squash_if
    import fetch_unit_squash_pkg::*;
#(
    parameter int p_seq_num_bits = SEQ_NUM_BITS
);
    logic                      mem_req_val;
    logic                      mem_req_rdy;
    logic [31:0]               mem_req_addr;
    logic                      mem_resp_val;
    logic                      mem_resp_rdy;
    logic [31:0]               mem_resp_data;
    logic                      F_val;
    logic                      F_rdy;
    logic [31:0]               F_inst;
    logic [31:0]               F_pc;
    logic [p_seq_num_bits-1:0] F_seq_num;
    logic                      squash_val;
    logic [31:0]               squash_target;
    logic [p_seq_num_bits-1:0] squash_seq_num;

    // master is the fetch unit, slave is the memory/decode environment
    modport master (
        output mem_req_val, mem_req_addr, mem_resp_rdy, F_val, F_inst, F_pc, F_seq_num,
        input  mem_req_rdy, mem_resp_val, mem_resp_data, F_rdy,
               squash_val, squash_target, squash_seq_num
    );
    modport slave (
        input  mem_req_val, mem_req_addr, mem_resp_rdy, F_val, F_inst, F_pc, F_seq_num,
        output mem_req_rdy, mem_resp_val, mem_resp_data, F_rdy,
               squash_val, squash_target, squash_seq_num
    );
endinterface

// File: rtl/fetch_unit_squash_pc_queue.sv
// In-order FIFO of issued fetch PCs; head is the PC of the oldest outstanding request.
// Zero-latency head, no internal backpressure: caller never pushes when full or pops when empty.
module fetch_pc_queue #(
    parameter int p_depth = 2,
    parameter int p_width = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [p_width-1:0] push_dat,
    input  logic               pop,
    output logic [p_width-1:0] head_dat,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int CNT_W = $clog2(p_depth + 1);

    logic [p_width-1:0] mem [p_depth];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == CNT_W'(p_depth));
    assign empty    = (count == '0);
endmodule

// File: rtl/fetch_unit_squash.sv
// In-order fetch with squash redirect; responses pass combinationally to decode (0 cycles).
// Requests stop at p_max_in_flight outstanding; F_rdy backpressures memory except while draining stale responses.
module fetch_unit_squash
    import fetch_unit_squash_pkg::*;
#(
    parameter logic [31:0] p_rst_addr      = RST_ADDR,
    parameter int          p_seq_num_bits  = SEQ_NUM_BITS,
    parameter int          p_max_in_flight = 2
) (
    input  logic                clk,
    input  logic                rst,
    fetch_unit_squash_if.master io
);
    localparam int               CNT_W   = $clog2(p_max_in_flight + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(p_max_in_flight);

    logic [31:0]               pc;
    logic [CNT_W-1:0]          in_flight;
    logic [CNT_W-1:0]          drop_cnt;
    logic [p_seq_num_bits-1:0] seq;
    logic [31:0]               q_head;
    logic                      q_full;
    logic                      q_empty;
    logic                      fwd;
    logic                      req_xfer;
    logic                      resp_xfer;
    logic                      f_xfer;

    // Forward only when nothing stale is outstanding and no redirect is in progress
    always_comb begin
        fwd              = (drop_cnt == '0) && !io.squash_val;
        io.mem_req_val   = !rst && (in_flight < MAX_CNT) && !io.squash_val;
        io.mem_req_addr  = pc;
        io.F_val         = !rst && fwd && io.mem_resp_val;
        io.F_inst        = io.mem_resp_data;
        io.F_pc          = q_head;
        io.F_seq_num     = seq;
        io.mem_resp_rdy  = fwd ? io.F_rdy : 1'b1;
        req_xfer         = io.mem_req_val && io.mem_req_rdy;
        resp_xfer        = io.mem_resp_val && io.mem_resp_rdy;
        f_xfer           = io.F_val && io.F_rdy;
    end

    fetch_pc_queue #(
        .p_depth (p_max_in_flight),
        .p_width (32)
    ) u_pc_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (req_xfer),
        .push_dat (pc),
        .pop      (resp_xfer),
        .head_dat (q_head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= p_rst_addr;
            in_flight <= '0;
            drop_cnt  <= '0;
            seq       <= '0;
        end else begin
            in_flight <= in_flight + CNT_W'(req_xfer) - CNT_W'(resp_xfer);
            if (io.squash_val) begin
                // Everything still outstanding after this cycle belongs to the old path
                pc       <= io.squash_target;
                seq      <= io.squash_seq_num + p_seq_num_bits'(1);
                drop_cnt <= in_flight - CNT_W'(resp_xfer);
            end else begin
                if (req_xfer) pc <= pc + 32'(INST_BYTES);
                if (f_xfer)   seq <= seq + p_seq_num_bits'(1);
                if (resp_xfer && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    a_resp_needs_pending: assert property (@(posedge clk) disable iff (rst)
        io.mem_resp_val |-> !q_empty);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        req_xfer |-> !q_full);
endmodule

// File: tb/tb_fetch_unit_squash.sv
// Randomized bench for fetch_unit_squash with an epoch-tagged memory/decode reference model.
module tb_fetch_unit_squash;
    import fetch_unit_squash_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_squash_if #(.p_seq_num_bits(5)) bus ();

    fetch_unit_squash #(
        .p_rst_addr      (32'h200),
        .p_seq_num_bits  (5),
        .p_max_in_flight (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    req_t        memq[$];
    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    logic [31:0] next_pc = 32'h200;
    logic [4:0]  exp_seq = 5'd0;

    int          req_pct = 100, resp_pct = 100, frdy_pct = 100;
    bit          rst_cfg = 1'b1;
    bit          sq = 1'b0;
    logic [31:0] sq_tgt = 32'h0;
    logic [4:0]  sq_seq = 5'd0;

    int          f_count = 0;
    logic [31:0] last_f_pc;
    logic [4:0]  last_f_seq;
    bit          last_req_x;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic model_reset();
        memq.delete();
        next_pc = 32'h200;
        exp_seq = 5'd0;
        epoch++;
    endtask

    // One clock: drive at negedge, check 1ns later, then advance the model with the observed handshakes
    task automatic step();
        bit stale, exp_req_val, exp_f_val, exp_resp_rdy, rx, px, fx;
        @(negedge clk);
        rst = rst_cfg;
        if (rst_cfg) model_reset();
        bus.mem_req_rdy    = roll(req_pct);
        bus.F_rdy          = roll(frdy_pct);
        bus.squash_val     = sq;
        bus.squash_target  = sq ? sq_tgt : $urandom;
        bus.squash_seq_num = sq ? sq_seq : 5'($urandom);
        bus.mem_resp_val   = !rst_cfg && (memq.size() > 0) && roll(resp_pct);
        bus.mem_resp_data  = (memq.size() > 0) ? mem_word(memq[0].addr) : $urandom;
        #1;
        stale = 1'b0;
        foreach (memq[i]) if (memq[i].epoch != epoch) stale = 1'b1;
        exp_req_val  = !rst_cfg && (memq.size() < 2) && !sq;
        exp_f_val    = !rst_cfg && bus.mem_resp_val && !sq && !stale;
        exp_resp_rdy = (sq || stale) ? 1'b1 : bus.F_rdy;

        checks++;
        if (bus.mem_req_val !== exp_req_val) begin
            errors++;
            $display("FAIL req_val: got %b want %b at %0t", bus.mem_req_val, exp_req_val, $time);
        end
        checks++;
        if (bus.F_val !== exp_f_val) begin
            errors++;
            $display("FAIL f_val: got %b want %b at %0t", bus.F_val, exp_f_val, $time);
        end
        checks++;
        if (bus.mem_resp_rdy !== exp_resp_rdy) begin
            errors++;
            $display("FAIL resp_rdy: got %b want %b at %0t", bus.mem_resp_rdy, exp_resp_rdy, $time);
        end
        if (exp_req_val && bus.mem_req_val) begin
            checks++;
            if (bus.mem_req_addr !== next_pc) begin
                errors++;
                $display("FAIL req_addr: got %h want %h at %0t", bus.mem_req_addr, next_pc, $time);
            end
        end
        if (exp_f_val && bus.F_val) begin
            checks++;
            if (bus.F_pc !== memq[0].addr || bus.F_inst !== mem_word(memq[0].addr)
                || bus.F_seq_num !== exp_seq) begin
                errors++;
                $display("FAIL f_payload: got pc %h inst %h seq %0d want pc %h inst %h seq %0d at %0t",
                         bus.F_pc, bus.F_inst, bus.F_seq_num, memq[0].addr,
                         mem_word(memq[0].addr), exp_seq, $time);
            end
        end

        rx = bus.mem_req_val && bus.mem_req_rdy;
        px = bus.mem_resp_val && bus.mem_resp_rdy;
        fx = bus.F_val && bus.F_rdy;
        if (px && memq.size() > 0) void'(memq.pop_front());
        if (fx) begin
            f_count++;
            last_f_pc  = bus.F_pc;
            last_f_seq = bus.F_seq_num;
            exp_seq++;
        end
        if (rx) begin
            memq.push_back('{addr: bus.mem_req_addr, epoch: epoch});
            next_pc += 32'd4;
        end
        last_req_x    = rx;
        last_req_addr = bus.mem_req_addr;
        if (sq) begin
            epoch++;
            next_pc = sq_tgt;
            exp_seq = sq_seq + 5'd1;
        end
    endtask

    task automatic wait_delivery(output bit got);
        int f0 = f_count;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            got = (f_count != f0);
        end
    endtask

    task automatic set_knobs(input int rq, input int rp, input int fr);
        req_pct = rq; resp_pct = rp; frdy_pct = fr;
    endtask

    task automatic test_reset();
        bus.mem_req_rdy = 1'b0; bus.mem_resp_val = 1'b0; bus.mem_resp_data = '0;
        bus.F_rdy = 1'b0; bus.squash_val = 1'b0; bus.squash_target = '0; bus.squash_seq_num = '0;
        #1;
        checks++;
        if (bus.mem_req_val !== 1'b0 || bus.F_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got req %b f %b want 0 0", bus.mem_req_val, bus.F_val);
        end
        set_knobs(100, 100, 100);
        rst_cfg = 1'b1;
        step();
        step();
        rst_cfg = 1'b0;
        step();
        checks++;
        if (bus.mem_req_val !== 1'b1 || bus.mem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL first_req: got val %b addr %h want 1 00000200", bus.mem_req_val, bus.mem_req_addr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] pcs[3];
        logic [4:0]  seqs[3];
        int n = 0;
        int f0 = f_count;
        set_knobs(100, 100, 100);
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (f_count != f0) begin
                pcs[n] = last_f_pc; seqs[n] = last_f_seq; n++; f0 = f_count;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL basic_timeout: got %0d deliveries want 3", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (pcs[k] !== 32'h200 + 32'(4 * k) || seqs[k] !== 5'(k)) begin
                errors++;
                $display("FAIL basic_stream%0d: got pc %h seq %0d want pc %h seq %0d",
                         k, pcs[k], seqs[k], 32'h200 + 32'(4 * k), k);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] p0 = last_f_pc;
        bit got;
        set_knobs(100, 100, 0);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.mem_req_val !== 1'b0 || bus.F_val !== 1'b1 || bus.mem_resp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got req %b f %b resp_rdy %b want 0 1 0",
                     bus.mem_req_val, bus.F_val, bus.mem_resp_rdy);
        end
        set_knobs(100, 100, 100);
        wait_delivery(got);
        checks++;
        if (!got || last_f_pc !== p0 + 32'd4) begin
            errors++;
            $display("FAIL stall_resume: got pc %h (delivered %b) want %h", last_f_pc, got, p0 + 32'd4);
        end
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_squash_drain();
        bit got;
        set_knobs(100, 0, 100);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.mem_req_val !== 1'b0) begin
            errors++;
            $display("FAIL full_gate: got req %b want 0", bus.mem_req_val);
        end
        sq = 1'b1; sq_tgt = 32'h400; sq_seq = 5'd3;
        step();
        sq = 1'b0;
        set_knobs(100, 100, 100);
        wait_delivery(got);
        checks++;
        if (!got || last_f_pc !== 32'h400 || last_f_seq !== 5'd4) begin
            errors++;
            $display("FAIL drain_redirect: got pc %h seq %0d want 400 4", last_f_pc, last_f_seq);
        end
    endtask

    task automatic test_squash_with_resp();
        bit got;
        set_knobs(100, 100, 100);
        for (int i = 0; i < 3; i++) step();
        sq = 1'b1; sq_tgt = 32'h600; sq_seq = 5'd10;
        step();
        sq = 1'b0;
        checks++;
        if (bus.mem_resp_rdy !== 1'b1 || bus.F_val !== 1'b0) begin
            errors++;
            $display("FAIL squash_resp_cycle: got resp_rdy %b f %b want 1 0", bus.mem_resp_rdy, bus.F_val);
        end
        wait_delivery(got);
        checks++;
        if (!got || last_f_pc !== 32'h600 || last_f_seq !== 5'd11) begin
            errors++;
            $display("FAIL squash_resp_redirect: got pc %h seq %0d want 600 11", last_f_pc, last_f_seq);
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        set_knobs(100, 100, 100);
        for (int i = 0; i < 3; i++) step();
        sq = 1'b1; sq_tgt = 32'h300; sq_seq = 5'd7;
        step();
        sq_tgt = 32'h500; sq_seq = 5'd20;
        step();
        sq = 1'b0;
        checks++;
        if (bus.mem_req_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gate: got req %b want 0", bus.mem_req_val);
        end
        wait_delivery(got);
        checks++;
        if (!got || last_f_pc !== 32'h500 || last_f_seq !== 5'd21) begin
            errors++;
            $display("FAIL b2b_redirect: got pc %h seq %0d want 500 21", last_f_pc, last_f_seq);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        set_knobs(70, 70, 70);
        for (int i = 0; i < 20; i++) step();
        rst_cfg = 1'b1;
        step();
        checks++;
        if (bus.mem_req_val !== 1'b0 || bus.F_val !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got req %b f %b want 0 0", bus.mem_req_val, bus.F_val);
        end
        rst_cfg = 1'b0;
        set_knobs(100, 100, 100);
        step();
        checks++;
        if (!last_req_x || last_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL mid_reset_restart: got xfer %b addr %h want 1 00000200", last_req_x, last_req_addr);
        end
        wait_delivery(got);
        checks++;
        if (!got || last_f_pc !== 32'h200 || last_f_seq !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_stream: got pc %h seq %0d want 200 0", last_f_pc, last_f_seq);
        end
    endtask

    task automatic test_random();
        int f0 = f_count;
        for (int ph = 0; ph < 15; ph++) begin
            set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(20, 100));
            for (int i = 0; i < 200; i++) begin
                sq     = roll(6);
                sq_tgt = (ph == 7) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
                sq_seq = 5'($urandom);
                step();
            end
            sq = 1'b0;
        end
        checks++;
        if (f_count - f0 < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d deliveries want at least 100", f_count - f0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_squash_drain();
        test_squash_with_resp();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
